mult_div_unit: RTL and testbench

//  Multicycle signed multiply/divide unit for MULT and DIV (funct 0x18/0x1A).

---
 rtl/mult_div_unit.sv | 259 +++++++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//
// Multicycle signed multiply/divide unit serving MULT and DIV. The control FSM
// pulses a start, holds its wait state while busy is high, and advances on
// done. Results land in the HI/LO registers, which feed MFHI/MFLO.
//
// Multiply: radix-2 Booth, one step per clock, DATA_WIDTH steps.
// Divide:   restoring division on operand magnitudes, one quotient bit per
//           clock, DATA_WIDTH steps, followed by a sign fix-up.
// A divide with a zero divisor is refused immediately: done and div_zero pulse
// for one cycle and HI/LO keep their previous contents.
//
// Ports
//   clk         in   1   clock, rising edge
//   reset       in   1   synchronous, active-low
//   start_mult  in   1   start signed op_a*op_b (sampled in IDLE, has priority)
//   start_div   in   1   start signed op_a/op_b (sampled in IDLE)
//   op_a        in   W   multiplicand / dividend
//   op_b        in   W   multiplier / divisor
//   hi          out  W   product upper half or remainder
//   lo          out  W   product lower half or quotient
//   busy        out  1   operation in progress
//   done        out  1   one-cycle pulse: hi/lo updated (or div_zero raised)
//   div_zero    out  1   one-cycle pulse alongside done for a zero divisor
// ---------------------------------------------------------------------------
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_mult,
    input  logic                  start_div,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * W + 1;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [W-1:0]  ONE_W     = W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_ITER = 2'd1,
        S_DIV_ITER = 2'd2,
        S_FINISH   = 2'd3
    } state_t;

    // Control state (reset)
    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          is_div_q, is_div_d;
    logic [W-1:0]  hi_q, hi_d;
    logic [W-1:0]  lo_q, lo_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;

    // Datapath state (no reset; always loaded before use)
    // work_q layout for multiply: {acc[W-1:0], Q[W-1:0], q_minus1}
    // work_q layout for divide:   {1'b0, rem[W-1:0], quo[W-1:0]}
    logic [PW-1:0] work_q, work_d;
    logic [W-1:0]  opnd_q, opnd_d;
    logic          q_neg_q, q_neg_d;
    logic          r_neg_q, r_neg_d;

    // -----------------------------------------------------------------------
    // Arithmetic helpers
    // -----------------------------------------------------------------------

    // Two's-complement magnitude. The most negative value maps onto itself,
    // which is still the correct unsigned magnitude 2^(W-1).
    function automatic logic [W-1:0] abs_val(input logic [W-1:0] x);
        return x[W-1] ? (~x + ONE_W) : x;
    endfunction

    // Conditional two's-complement negation used for the divide sign fix-up.
    function automatic logic [W-1:0] neg_if(input logic [W-1:0] x,
                                             input logic         neg);
        return neg ? (~x + ONE_W) : x;
    endfunction

    // One Booth step. The add/subtract is done one bit wider than acc so that
    // subtracting the most negative multiplicand cannot overflow; the extra
    // bit is absorbed by the arithmetic right shift that follows.
    function automatic logic [PW-1:0] booth_step(input logic [PW-1:0] p,
                                                 input logic [W-1:0]  m);
        logic signed [W:0] acc_ext;
        logic signed [W:0] m_ext;
        logic signed [W:0] sum;
        acc_ext = {p[PW-1], p[PW-1:W+1]};
        m_ext   = {m[W-1], m};
        case (p[1:0])
            2'b01:   sum = acc_ext + m_ext;
            2'b10:   sum = acc_ext - m_ext;
            default: sum = acc_ext;
        endcase
        // {sum, Q} is {sum, Q, q-1} shifted right by one with q-1 dropped.
        return {sum, p[W:1]};
    endfunction

    // One restoring-division step on magnitudes: shift the next dividend bit
    // into the partial remainder, subtract the divisor if it fits.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                                 input logic [W-1:0] quo,
                                                 input logic [W-1:0] d);
        logic [W:0]   shifted;
        logic         fits;
        logic [W-1:0] new_rem;
        shifted = {rem, quo[W-1]};
        fits    = (shifted >= {1'b0, d});
        new_rem = fits ? (shifted[W-1:0] - d) : shifted[W-1:0];
        return {new_rem, quo[W-2:0], fits};
    endfunction

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // Multiply wins when both starts arrive together.
                if (start_mult) begin
                    state_d = S_MUL_ITER;
                end else if (start_div && (op_b != '0)) begin
                    state_d = S_DIV_ITER;
                end
            end
            S_MUL_ITER,
            S_DIV_ITER: begin
                if (count_q == LAST_STEP) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: output / datapath next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        count_d  = count_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        work_d   = work_q;
        opnd_d   = opnd_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;

        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (start_mult) begin
                    is_div_d = 1'b0;
                    opnd_d   = op_a;
                    work_d   = {{W{1'b0}}, op_b, 1'b0};
                end else if (start_div) begin
                    if (op_b == '0) begin
                        // Refused without entering the iteration; HI/LO kept.
                        done_d = 1'b1;
                        dz_d   = 1'b1;
                    end else begin
                        is_div_d = 1'b1;
                        opnd_d   = abs_val(op_b);
                        work_d   = {1'b0, {W{1'b0}}, abs_val(op_a)};
                        // Quotient truncates toward zero; remainder follows
                        // the dividend's sign.
                        q_neg_d  = op_a[W-1] ^ op_b[W-1];
                        r_neg_d  = op_a[W-1];
                    end
                end
            end
            S_MUL_ITER: begin
                work_d  = booth_step(work_q, opnd_q);
                count_d = count_q + CNT_ONE;
            end
            S_DIV_ITER: begin
                work_d  = {1'b0, div_step(work_q[2*W-1:W], work_q[W-1:0], opnd_q)};
                count_d = count_q + CNT_ONE;
            end
            S_FINISH: begin
                done_d = 1'b1;
                if (is_div_q) begin
                    // -2^(W-1) / -1 leaves the magnitude 2^(W-1) unnegated,
                    // which reads back as 0x80..0 as intended.
                    lo_d = neg_if(work_q[W-1:0], q_neg_q);
                    hi_d = neg_if(work_q[2*W-1:W], r_neg_q);
                end else begin
                    hi_d = work_q[2*W:W+1];
                    lo_d = work_q[W:1];
                end
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control and result registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q  <= '0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            count_q  <= count_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        work_q  <= work_d;
        opnd_q  <= opnd_d;
        q_neg_q <= q_neg_d;
        r_neg_q <= r_neg_d;
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Reference arithmetic: plain 64-bit signed math.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p;
    endfunction

    // Returns {remainder, quotient}; SV division truncates toward zero and the
    // remainder carries the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Transaction-level model: an accepted operation completes 33 edges later.
    int          m_rem = 0;
    logic [63:0] m_res;
    logic [31:0] m_hi, m_lo;
    logic        m_done, m_dz;

    always @(posedge clk) begin
        if (!reset) begin
            m_rem  <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    {m_hi, m_lo} <= m_res;
                    m_done       <= 1'b1;
                end
            end else if (start_mult) begin
                m_res <= ref_mul(op_a, op_b);
                m_rem <= 33;
            end else if (start_div) begin
                if (op_b == 32'd0) begin
                    m_done <= 1'b1;
                    m_dz   <= 1'b1;
                end else begin
                    m_res <= ref_div(op_a, op_b);
                    m_rem <= 33;
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hi",       hi,              m_hi);
            chk("lo",       lo,              m_lo);
            chk("busy",     32'(busy),       32'(m_rem != 0));
            chk("done",     32'(done),       32'(m_done));
            chk("div_zero", 32'(div_zero),   32'(m_dz));
        end
    end

    // Present a start for one edge, then scramble operands to show they are
    // not re-sampled. Returns on the negedge after the start edge.
    task automatic start_op(input logic sm, input logic sd,
                            input logic [31:0] a, input logic [31:0] b);
        start_mult = sm;
        start_div  = sd;
        op_a       = a;
        op_b       = b;
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
    endtask

    // Wait the remaining cycles to the done cycle and check literal results.
    task automatic expect_result(input string name, input int wait_n,
                                 input logic [31:0] eh, input logic [31:0] el);
        repeat (wait_n) @(negedge clk);
        chk({name, ".done"}, 32'(done), 32'd1);
        chk({name, ".hi"},   hi, eh);
        chk({name, ".lo"},   lo, el);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (3) @(negedge clk);
        reset  = 1'b1;
        chk_en = 1'b1;
        chk("reset.hi",   hi,        32'd0);
        chk("reset.lo",   lo,        32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);

        // 7 * -3 = -21
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("mul7.busy", 32'(busy), 32'd1);
        expect_result("mul7", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Largest positive squared, then most negative squared back-to-back.
        start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        expect_result("mulmax", 33, 32'h3FFF_FFFF, 32'h0000_0001);
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        expect_result("mulmin", 33, 32'h4000_0000, 32'h0000_0000);

        // Divides
        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        expect_result("div-7/2", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        expect_result("div100/7", 33, 32'd2, 32'd14);
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        expect_result("divovf", 33, 32'd0, 32'h8000_0000);

        // Prime hi=0x12, lo=0x34 (0x692 / 0x20), then divide by zero.
        start_op(1'b0, 1'b1, 32'h0000_0692, 32'h0000_0020);
        expect_result("prime", 33, 32'h12, 32'h34);
        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        chk("dz.done", 32'(done),     32'd1);
        chk("dz.flag", 32'(div_zero), 32'd1);
        chk("dz.busy", 32'(busy),     32'd0);
        chk("dz.hi",   hi,            32'h12);
        chk("dz.lo",   lo,            32'h34);
        @(negedge clk);
        chk("dz.done_drop", 32'(done),     32'd0);
        chk("dz.flag_drop", 32'(div_zero), 32'd0);

        // Stray start_mult while a divide is busy.
        start_op(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start_mult = 1'b1;
        op_a       = 32'd3;
        op_b       = 32'd3;
        @(negedge clk);
        start_mult = 1'b0;
        expect_result("stray", 28, 32'd2, 32'd14);

        // Both starts together: multiply wins (6 * -2 = -12).
        start_op(1'b1, 1'b1, 32'd6, 32'hFFFF_FFFE);
        expect_result("both", 33, 32'hFFFF_FFFF, 32'hFFFF_FFF4);

        // Reset during a multiply.
        start_op(1'b1, 1'b0, 32'h1234, 32'h5678);
        repeat (8) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.hi",   hi,        32'd0);
        chk("rst.lo",   lo,        32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        expect_result("postrst", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Randomized traffic, including starts while busy and rare resets.
        for (int i = 0; i < 4000; i++) begin
            start_mult = ($urandom_range(0, 5) == 0);
            start_div  = ($urandom_range(0, 3) == 0);
            op_a       = pick();
            op_b       = pick();
            reset      = ($urandom_range(0, 599) != 0);
            @(negedge clk);
        end
        start_mult = 1'b0;
        start_div  = 1'b0;
        reset      = 1'b1;
        repeat (40) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
